// File: rtl/act_wb_arbiter_pkg.sv
// act_wb_pkg: shared lane geometry, FIFO entry type and round-robin helper for the write-back scheduler.
package act_wb_pkg;
    localparam int ACC_NUM       = 16;
    localparam int FA_NUM        = 1;
    localparam int ADDRESS_WIDTH = 10;
    localparam int DATA_WIDTH    = 8;
    localparam int LANES         = ACC_NUM + FA_NUM;
    localparam int LW            = $clog2(LANES);
    localparam int FC_LANE       = ACC_NUM;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    data;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic                     last;
    } entry_t;

    function automatic logic [LW-1:0] rr_next(input logic [LW-1:0] g);
        return (g == LW'(LANES - 1)) ? '0 : g + 1'b1;
    endfunction
endpackage

// File: rtl/act_wb_arbiter_if.sv
// act_wb_arbiter_if: activation-lane inputs and global-buffer write port of the write-back scheduler.
interface act_wb_arbiter_if;
    import act_wb_pkg::*;
    logic                             start_i;
    logic [LANES-1:0]                 lane_en_i;
    logic [LANES-1:0]                 act_valid_i;
    logic [LANES-1:0]                 act_last_i;
    logic [LANES*DATA_WIDTH-1:0]      act_result_i;
    logic [ACC_NUM*ADDRESS_WIDTH-1:0] act_result_address_i;
    logic                             wr_valid_o;
    logic                             wr_ready_i;
    logic [LW+ADDRESS_WIDTH-1:0]      wr_addr_o;
    logic [DATA_WIDTH-1:0]            wr_data_o;
    logic                             wr_last_o;
    logic                             busy_o;
    logic                             done_o;
    logic                             overflow_o;

    modport slave (
        input  start_i, lane_en_i, act_valid_i, act_last_i, act_result_i, act_result_address_i, wr_ready_i,
        output wr_valid_o, wr_addr_o, wr_data_o, wr_last_o, busy_o, done_o, overflow_o
    );
    modport master (
        output start_i, lane_en_i, act_valid_i, act_last_i, act_result_i, act_result_address_i, wr_ready_i,
        input  wr_valid_o, wr_addr_o, wr_data_o, wr_last_o, busy_o, done_o, overflow_o
    );
endinterface

// File: rtl/act_wb_arbiter_lane_fifo.sv
// act_wb_lane_fifo: per-lane sync FIFO; a push into a full FIFO survives only if a pop frees a slot that cycle.
module act_wb_lane_fifo
    import act_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  logic   pop_i,
    input  entry_t din_i,
    output entry_t dout_o,
    output logic   empty_o,
    output logic   drop_o
);
    localparam int AW = $clog2(DEPTH);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          full, wr;

    assign empty_o = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign wr      = push_i & (~full | pop_i);
    assign drop_o  = push_i & full & ~pop_i;
    assign dout_o  = mem_q[rp_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_q + AW'(wr);
            rp_q  <= rp_q + AW'(pop_i);
            cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= din_i;
    end
endmodule

// File: rtl/act_wb_arbiter.sv
// act_wb_arbiter: buffers every activation lane and shares one global-buffer write port round-robin.
module act_wb_arbiter
    import act_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    act_wb_arbiter_if.slave bus
);
    entry_t                      dout [LANES];
    logic [LANES-1:0]            empty, drop, pop, clr, pend_q, pend_d;
    logic [ADDRESS_WIDTH-1:0]    fc_cnt_q;
    logic [LW-1:0]               rr_q, g, idx, hs_lane;
    logic                        any, can_load, hs, start_acc, act, fin;
    logic                        busy_q, done_q, ovf_q;
    logic                        wr_valid_q, wr_last_q;
    logic [LW+ADDRESS_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0]       wr_data_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [ADDRESS_WIDTH-1:0] addr;
        if (k < ACC_NUM) begin : g_conv
            assign addr = bus.act_result_address_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        end else begin : g_fc
            assign addr = fc_cnt_q;
        end
        act_wb_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk    (clk),
            .rst_n  (rst_n),
            .push_i (bus.act_valid_i[k]),
            .pop_i  (pop[k]),
            .din_i  (entry_t'{bus.act_result_i[k*DATA_WIDTH +: DATA_WIDTH], addr, bus.act_last_i[k]}),
            .dout_o (dout[k]),
            .empty_o(empty[k]),
            .drop_o (drop[k])
        );
    end

    // first non-empty lane at or after rr_q, wrapping
    always_comb begin
        g   = rr_q;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            idx = LW'((int'(rr_q) + i) % LANES);
            if (!any && !empty[idx]) begin
                any = 1'b1;
                g   = idx;
            end
        end
    end

    assign can_load  = ~wr_valid_q | bus.wr_ready_i;
    assign pop       = (can_load & any) ? (LANES'(1) << g) : '0;
    assign hs        = wr_valid_q & bus.wr_ready_i;
    assign hs_lane   = wr_addr_q[LW+ADDRESS_WIDTH-1 -: LW];
    assign clr       = (hs & wr_last_q) ? (LANES'(1) << hs_lane) : '0;
    assign start_acc = bus.start_i & ~busy_q;
    assign pend_d    = start_acc ? bus.lane_en_i : (pend_q & ~clr);
    assign act       = busy_q | start_acc;
    assign fin       = act & ~|pend_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            fc_cnt_q   <= '0;
            rr_q       <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_last_q  <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            busy_q   <= act & ~fin;
            done_q   <= fin;
            ovf_q    <= ovf_q | |drop;
            fc_cnt_q <= start_acc ? '0 : fc_cnt_q + ADDRESS_WIDTH'(bus.act_valid_i[FC_LANE]);
            if (can_load && any) begin
                wr_valid_q <= 1'b1;
                wr_addr_q  <= {g, dout[g].addr};
                wr_data_q  <= dout[g].data;
                wr_last_q  <= dout[g].last;
                rr_q       <= rr_next(g);
            end else if (bus.wr_ready_i) begin
                wr_valid_q <= 1'b0;
            end
        end
    end

    assign bus.wr_valid_o = wr_valid_q;
    assign bus.wr_addr_o  = wr_addr_q;
    assign bus.wr_data_o  = wr_data_q;
    assign bus.wr_last_o  = wr_last_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_act_wb_arbiter.sv
// tb_act_wb_arbiter: directed scoreboard bench for the write-back scheduler.
module tb_act_wb_arbiter;
    import act_wb_pkg::*;

    typedef logic [LW+ADDRESS_WIDTH+DATA_WIDTH:0] beat_t;

    logic  clk = 1'b0;
    logic  rst_n;
    beat_t sb [$];
    int    checks = 0, errors = 0, wr_cnt = 0, done_cnt = 0;
    int    n, d0, w0;

    always #5 clk = ~clk;

    act_wb_arbiter_if bus ();
    act_wb_arbiter u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int lane, input int addr, input int data, input bit last, input bit keep);
        bus.act_valid_i[lane] = 1'b1;
        bus.act_last_i[lane]  = last;
        bus.act_result_i[lane*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(data);
        if (lane < ACC_NUM) bus.act_result_address_i[lane*ADDRESS_WIDTH +: ADDRESS_WIDTH] = ADDRESS_WIDTH'(addr);
        if (keep) sb.push_back({LW'(lane), ADDRESS_WIDTH'(addr), DATA_WIDTH'(data), last});
    endtask

    task automatic idle_in();
        bus.act_valid_i = '0;
        bus.act_last_i  = '0;
    endtask

    task automatic start(input logic [LANES-1:0] en);
        bus.start_i   = 1'b1;
        bus.lane_en_i = en;
        tick();
        bus.start_i   = 1'b0;
        bus.lane_en_i = '0;
    endtask

    task automatic drain(input int maxc, output int cyc);
        cyc = 0;
        while (sb.size() != 0 && cyc < maxc) begin
            tick();
            cyc++;
        end
        chk("drained", 32'(sb.size()), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done_o) done_cnt++;
            if (bus.wr_valid_o && bus.wr_ready_i) begin
                wr_cnt++;
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_write: observed addr %0h data %0h, expected no write", bus.wr_addr_o, bus.wr_data_o);
                end
                if (sb.size() != 0) chk("wr_beat", 32'({bus.wr_addr_o, bus.wr_data_o, bus.wr_last_o}), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        rst_n                    = 1'b0;
        bus.start_i              = 1'b0;
        bus.lane_en_i            = '0;
        bus.act_valid_i          = '0;
        bus.act_last_i           = '0;
        bus.act_result_i         = '0;
        bus.act_result_address_i = '0;
        bus.wr_ready_i           = 1'b1;
        tick();
        chk("rst_wr_valid", 32'(bus.wr_valid_o), 0);
        chk("rst_wr_addr", 32'(bus.wr_addr_o), 0);
        chk("rst_wr_data", 32'(bus.wr_data_o), 0);
        chk("rst_wr_last", 32'(bus.wr_last_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_done", 32'(bus.done_o), 0);
        chk("rst_overflow", 32'(bus.overflow_o), 0);
        rst_n = 1'b1;
        tick();

        // single lane: latency, beat contents, done one cycle after the handshake
        start(17'h00001);
        chk("t1_busy", 32'(bus.busy_o), 1);
        push(0, 5, 'h3C, 1'b1, 1'b1);
        tick();
        idle_in();
        chk("t1_valid_t1", 32'(bus.wr_valid_o), 0);
        tick();
        chk("t1_valid_t2", 32'(bus.wr_valid_o), 1);
        chk("t1_addr", 32'(bus.wr_addr_o), 5);
        chk("t1_data", 32'(bus.wr_data_o), 'h3C);
        chk("t1_last", 32'(bus.wr_last_o), 1);
        tick();
        chk("t1_done", 32'(bus.done_o), 1);
        chk("t1_busy_drop", 32'(bus.busy_o), 0);
        tick();
        chk("t1_done_pulse", 32'(bus.done_o), 0);

        // all 17 lanes at once: lane order, FC addr 0, one write per cycle
        do_reset();
        start('1);
        for (int k = 0; k < ACC_NUM; k++) push(k, k * 7 + 3, 'h10 + k, 1'b1, 1'b1);
        push(FC_LANE, 0, 'hA5, 1'b1, 1'b1);
        tick();
        idle_in();
        d0 = done_cnt;
        drain(40, n);
        chk("t2_cycles", 32'(n), 18);
        tick();
        chk("t2_done_cnt", 32'(done_cnt - d0), 1);
        chk("t2_busy", 32'(bus.busy_o), 0);

        // FC address counter counts pushes and restarts on start
        start(17'h10000);
        push(FC_LANE, 0, 'h51, 1'b0, 1'b1);
        tick();
        push(FC_LANE, 1, 'h52, 1'b0, 1'b1);
        tick();
        push(FC_LANE, 2, 'h53, 1'b1, 1'b1);
        tick();
        idle_in();
        d0 = done_cnt;
        drain(20, n);
        tick();
        chk("t3_done_cnt", 32'(done_cnt - d0), 1);
        start(17'h10000);
        push(FC_LANE, 0, 'h60, 1'b1, 1'b1);
        tick();
        idle_in();
        drain(20, n);

        // stall with 6 pushes on lane 3: one dropped, outputs hold
        chk("t4_ovf_before", 32'(bus.overflow_o), 0);
        bus.wr_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(3, 100 + i, 'h40 + i, 1'b0, i < 5);
            tick();
        end
        idle_in();
        for (int i = 0; i < 4; i++) begin
            chk("t4_hold_valid", 32'(bus.wr_valid_o), 1);
            chk("t4_hold_addr", 32'(bus.wr_addr_o), (3 << ADDRESS_WIDTH) | 100);
            chk("t4_hold_data", 32'(bus.wr_data_o), 'h40);
            tick();
        end
        chk("t4_overflow", 32'(bus.overflow_o), 1);
        bus.wr_ready_i = 1'b1;
        w0 = wr_cnt;
        drain(20, n);
        repeat (3) tick();
        chk("t4_writes", 32'(wr_cnt - w0), 5);
        chk("t4_ovf_sticky", 32'(bus.overflow_o), 1);

        // fairness: lanes 2 and 9 alternate
        do_reset();
        chk("t5_ovf_reset", 32'(bus.overflow_o), 0);
        push(2, 20, 'h21, 1'b0, 1'b1);
        push(9, 90, 'h91, 1'b0, 1'b1);
        tick();
        push(2, 21, 'h22, 1'b0, 1'b1);
        push(9, 91, 'h92, 1'b0, 1'b1);
        tick();
        idle_in();
        drain(20, n);
        chk("t5_cycles", 32'(n), 4);

        // reset mid-flight discards buffered entries
        bus.wr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(5, 50 + i, 'h55 + i, 1'b0, 1'b0);
            tick();
        end
        idle_in();
        tick();
        chk("t6_valid_before", 32'(bus.wr_valid_o), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_valid_async", 32'(bus.wr_valid_o), 0);
        chk("t6_addr_async", 32'(bus.wr_addr_o), 0);
        chk("t6_data_async", 32'(bus.wr_data_o), 0);
        tick();
        rst_n = 1'b1;
        bus.wr_ready_i = 1'b1;
        w0 = wr_cnt;
        repeat (10) tick();
        chk("t6_no_writes", 32'(wr_cnt - w0), 0);
        chk("t6_valid_after", 32'(bus.wr_valid_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
